// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, latches imem data into the instruction register,
// and handles launch, stall, branch redirect with flush, and halt on DONE.
module instr_fetch #(
  parameter int                PC_W    = 8,
  parameter int                INSTR_W = 9,
  parameter logic [PC_W-1:0]   ENTRY0  = 8'd0,
  parameter logic [PC_W-1:0]   ENTRY1  = 8'd26,
  parameter logic [PC_W-1:0]   ENTRY2  = 8'd45,
  parameter int                CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         start_sel,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    PC,
  input  logic [INSTR_W-1:0] iptr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               running,
  output logic               done,
  output logic [CNT_W-1:0]   cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]    PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [INSTR_W-1:0] INSTR_DONE = {INSTR_W{1'b0}};

  state_t               r_state, w_state_nxt;
  logic [PC_W-1:0]      r_pc, w_pc_nxt;
  logic [INSTR_W-1:0]   r_instr, w_instr_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_running, r_done;

  // Reserved select code 3 falls back to the first program.
  function automatic logic [PC_W-1:0] entry_pc(input logic [1:0] sel);
    case (sel)
      2'd1:    entry_pc = ENTRY1;
      2'd2:    entry_pc = ENTRY2;
      default: entry_pc = ENTRY0;
    endcase
  endfunction

  // Next-state and datapath decode; stall beats branch beats DONE beats fetch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = entry_pc(start_sel);
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_valid_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
          w_cnt_nxt = r_cnt;
        end
        if (stall) begin
          w_pc_nxt = r_pc;
        end else if (branch_taken && r_valid) begin
          // The fetch already in flight is wrong-path: drop it.
          w_pc_nxt    = branch_target;
          w_valid_nxt = 1'b0;
        end else if (r_valid && (r_instr == INSTR_DONE)) begin
          w_state_nxt = S_HALT;
          w_valid_nxt = 1'b0;
        end else begin
          w_instr_nxt = iptr;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = r_pc + PC_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_pc      <= {PC_W{1'b0}};
      r_instr   <= {INSTR_W{1'b0}};
      r_valid   <= 1'b0;
      r_cnt     <= {CNT_W{1'b0}};
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_valid   <= w_valid_nxt;
      r_cnt     <= w_cnt_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_done    <= (w_state_nxt == S_HALT);
    end
  end

  assign PC          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign running     = r_running;
  assign done        = r_done;
  assign cycle_cnt   = r_cnt;

endmodule
